// File: rtl/vis_serialiser.sv
// Visibility-pair to framed byte-stream serialiser.
// Frame: header, sequence, {re,im} payload MSB-first per pair, XOR checksum.
module vis_serialiser #(
  parameter int unsigned WIDTH  = 32,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic             bus_clock,
  input  logic             bus_reset,
  input  logic             vis_valid_i,
  output logic             vis_ready_o,
  input  logic             vis_last_i,
  input  logic [WIDTH-1:0] vis_revis_i,
  input  logic [WIDTH-1:0] vis_imvis_i,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic             byte_last_o,
  output logic [7:0]       byte_data_o,
  output logic [7:0]       frame_seq_o
);

  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned SW    = 2 * WIDTH;
  localparam int unsigned IDX_W = $clog2(2 * BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HEAD,
    SEQ,
    LOAD,
    DATA,
    SUM
  } state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    sreg, sreg_nxt;
  logic             last_q, last_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       chk, chk_nxt;
  logic [7:0]       seq_nxt;
  logic             valid_nxt;
  logic             blast_nxt;
  logic [7:0]       data_nxt;
  logic             ready_nxt;
  logic             out_xfer;
  logic             in_xfer;

  assign out_xfer = byte_valid_o & byte_ready_i;
  assign in_xfer  = vis_valid_i & vis_ready_o;

  // State and registered outputs; outputs are computed one cycle ahead
  always_ff @(posedge bus_clock or posedge bus_reset) begin
    if (bus_reset) begin
      state        <= IDLE;
      sreg         <= '0;
      last_q       <= 1'b0;
      idx          <= '0;
      chk          <= 8'h00;
      frame_seq_o  <= 8'h00;
      byte_valid_o <= 1'b0;
      byte_last_o  <= 1'b0;
      byte_data_o  <= 8'h00;
      vis_ready_o  <= 1'b0;
    end else begin
      state        <= state_nxt;
      sreg         <= sreg_nxt;
      last_q       <= last_nxt;
      idx          <= idx_nxt;
      chk          <= chk_nxt;
      frame_seq_o  <= seq_nxt;
      byte_valid_o <= valid_nxt;
      byte_last_o  <= blast_nxt;
      byte_data_o  <= data_nxt;
      vis_ready_o  <= ready_nxt;
    end
  end

  // Next state, datapath and next output values; everything holds unless a transfer occurs
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    last_nxt  = last_q;
    idx_nxt   = idx;
    chk_nxt   = chk;
    seq_nxt   = frame_seq_o;
    valid_nxt = byte_valid_o;
    blast_nxt = byte_last_o;
    data_nxt  = byte_data_o;
    ready_nxt = vis_ready_o;

    case (state)
      IDLE: begin
        if (vis_valid_i) begin
          state_nxt = HEAD;
          valid_nxt = 1'b1;
          blast_nxt = 1'b0;
          data_nxt  = HEADER;
          ready_nxt = 1'b0;
        end
      end

      HEAD: begin
        if (out_xfer) begin
          state_nxt = SEQ;
          data_nxt  = frame_seq_o;
        end
      end

      SEQ: begin
        if (out_xfer) begin
          state_nxt = LOAD;
          chk_nxt   = frame_seq_o;
          valid_nxt = 1'b0;
          data_nxt  = 8'h00;
          ready_nxt = 1'b1;
        end
      end

      LOAD: begin
        if (in_xfer) begin
          state_nxt = DATA;
          sreg_nxt  = {vis_revis_i, vis_imvis_i};
          last_nxt  = vis_last_i;
          idx_nxt   = '0;
          ready_nxt = 1'b0;
          valid_nxt = 1'b1;
          data_nxt  = vis_revis_i[WIDTH-1 -: 8];
        end
      end

      DATA: begin
        if (out_xfer) begin
          chk_nxt  = chk ^ byte_data_o;
          sreg_nxt = sreg << 8;
          idx_nxt  = idx + IDX_W'(1);
          if (idx == IDX_LAST) begin
            if (last_q) begin
              state_nxt = SUM;
              data_nxt  = chk ^ byte_data_o;
              blast_nxt = 1'b1;
            end else begin
              state_nxt = LOAD;
              valid_nxt = 1'b0;
              data_nxt  = 8'h00;
              ready_nxt = 1'b1;
            end
          end else begin
            data_nxt = sreg[SW-9 -: 8];
          end
        end
      end

      SUM: begin
        if (out_xfer) begin
          state_nxt = IDLE;
          seq_nxt   = frame_seq_o + 8'd1;
          valid_nxt = 1'b0;
          blast_nxt = 1'b0;
          data_nxt  = 8'h00;
        end
      end

      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        blast_nxt = 1'b0;
        data_nxt  = 8'h00;
        ready_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vis_serialiser.sv
// Directed bench for vis_serialiser: hand-computed frames plus a byte scoreboard.
module tb_vis_serialiser;

  logic        bus_clock = 1'b0;
  logic        bus_reset = 1'b1;
  logic        vis_valid_i = 1'b0;
  logic        vis_ready_o;
  logic        vis_last_i = 1'b0;
  logic [31:0] vis_revis_i = '0;
  logic [31:0] vis_imvis_i = '0;
  logic        byte_valid_o;
  logic        byte_ready_i = 1'b1;
  logic        byte_last_o;
  logic [7:0]  byte_data_o;
  logic [7:0]  frame_seq_o;

  vis_serialiser #(.WIDTH(32), .HEADER(8'hA5)) dut (
    .bus_clock    (bus_clock),
    .bus_reset    (bus_reset),
    .vis_valid_i  (vis_valid_i),
    .vis_ready_o  (vis_ready_o),
    .vis_last_i   (vis_last_i),
    .vis_revis_i  (vis_revis_i),
    .vis_imvis_i  (vis_imvis_i),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .byte_last_o  (byte_last_o),
    .byte_data_o  (byte_data_o),
    .frame_seq_o  (frame_seq_o)
  );

  always #5 bus_clock = ~bus_clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          rdy_cnt = 0;
  bit          rdy_rand = 1'b0;
  logic [8:0]  got_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] re_tab[4];
  logic [31:0] im_tab[4];
  logic        stall_prev = 1'b0;
  logic [9:0]  stall_snap = '0;

  // Count and report one comparison
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Downstream ready: either tied high or a coin flip each cycle
  always @(negedge bus_clock) byte_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;

  // Output monitor: capture transferred bytes, count accept cycles, verify hold while stalled
  always @(posedge bus_clock) begin
    if (bus_reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", 32'({byte_valid_o, byte_last_o, byte_data_o}), 32'(stall_snap));
      if (byte_valid_o && byte_ready_i) got_q.push_back({byte_last_o, byte_data_o});
      if (vis_ready_o) rdy_cnt++;
      stall_prev = byte_valid_o && !byte_ready_i;
      stall_snap = {byte_valid_o, byte_last_o, byte_data_o};
    end
  end

  // Present pairs 0..n-1 back to back; the next pair is offered while the current one serialises
  task automatic drive_frame(input int n);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 2000) begin
      @(negedge bus_clock);
      vis_valid_i = 1'b1;
      vis_revis_i = re_tab[k];
      vis_imvis_i = im_tab[k];
      vis_last_i  = (k == n - 1);
      @(posedge bus_clock);
      cyc++;
      if (vis_ready_o) k++;
    end
    @(negedge bus_clock);
    vis_valid_i = 1'b0;
    vis_last_i  = 1'b0;
    check("pairs_accepted", 32'(k), 32'(n));
  endtask

  // Wait, bounded, until nbytes have been transferred
  task automatic wait_bytes(input int nbytes);
    int cyc = 0;
    while (got_q.size() < nbytes && cyc < 1000) begin
      @(posedge bus_clock);
      cyc++;
    end
    @(negedge bus_clock);
    if (got_q.size() < nbytes) check("timeout", 32'(got_q.size()), 32'(nbytes));
  endtask

  // Reference byte stream for the first n table entries
  task automatic build_exp(input logic [7:0] seq, input int n);
    logic [7:0] c;
    logic [7:0] b;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq);
    c = seq;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < 4; i++) begin
        b = re_tab[p][31-8*i -: 8];
        exp_q.push_back(b);
        c = c ^ b;
      end
      for (int i = 0; i < 4; i++) begin
        b = im_tab[p][31-8*i -: 8];
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
    exp_q.push_back(c);
  endtask

  // Compare captured bytes and last flags against exp_q
  task automatic compare_frame(input string tag);
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i), 32'(got_q[i][7:0]), 32'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(got_q[i][8]), 32'(i == exp_q.size() - 1));
    end
  endtask

  task automatic run_frame(input int n, input int nbytes);
    got_q.delete();
    rdy_cnt = 0;
    drive_frame(n);
    wait_bytes(nbytes);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge bus_clock);
    #1;
    check("reset_outputs",
          32'({vis_ready_o, byte_valid_o, byte_last_o, byte_data_o, frame_seq_o}), 32'h0);
    @(negedge bus_clock);
    bus_reset = 1'b0;

    // Single pair frame, header one cycle after valid seen in IDLE
    re_tab[0] = 32'h01020304;
    im_tab[0] = 32'h05060708;
    got_q.delete();
    rdy_cnt = 0;
    @(negedge bus_clock);
    vis_valid_i = 1'b1;
    vis_revis_i = re_tab[0];
    vis_imvis_i = im_tab[0];
    vis_last_i  = 1'b1;
    @(posedge bus_clock);
    #1;
    check("hdr_latency", 32'({byte_valid_o, byte_data_o, vis_ready_o}), 32'({1'b1, 8'hA5, 1'b0}));
    drive_frame(1);
    wait_bytes(11);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    compare_frame("single");
    check("single_ready_cycles", 32'(rdy_cnt), 32'd1);
    check("single_seq_after", 32'(frame_seq_o), 32'h01);

    // Same frame again: sequence 01, checksum 09
    run_frame(1, 11);
    exp_q = '{8'hA5, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    compare_frame("repeat");

    // Run to 256 frames total; the final one carries sequence FF
    for (int f = 0; f < 254; f++) begin
      run_frame(1, 11);
      if (f == 253) begin
        exp_q = '{8'hA5, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hF7};
        compare_frame("seq_ff");
      end
    end
    check("seq_wrap", 32'(frame_seq_o), 32'h00);

    // Two-pair frame: 2 + 16 + 1 bytes, checksum FF
    re_tab[0] = 32'hFFFFFFFF; im_tab[0] = 32'h00000000;
    re_tab[1] = 32'h00000000; im_tab[1] = 32'h000000FF;
    run_frame(2, 19);
    exp_q = '{8'hA5, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    compare_frame("two_pair");
    check("two_pair_ready_cycles", 32'(rdy_cnt), 32'd2);

    // Four-pair frame, ready high then ready randomised
    re_tab = '{32'h11223344, 32'hDEADBEEF, 32'h80000001, 32'hCAFEF00D};
    im_tab = '{32'h55667788, 32'h0BADF00D, 32'h7FFFFFFE, 32'h12345678};
    run_frame(4, 35);
    build_exp(8'h01, 4);
    compare_frame("four_rdy");
    check("four_rdy_ready_cycles", 32'(rdy_cnt), 32'd4);
    rdy_rand = 1'b1;
    run_frame(4, 35);
    build_exp(8'h02, 4);
    compare_frame("four_rand");
    check("four_rand_ready_cycles", 32'(rdy_cnt), 32'd4);
    rdy_rand = 1'b0;
    @(negedge bus_clock);

    // Asynchronous reset after six bytes of a frame
    re_tab[0] = 32'h01020304;
    im_tab[0] = 32'h05060708;
    got_q.delete();
    @(negedge bus_clock);
    vis_valid_i = 1'b1;
    vis_revis_i = re_tab[0];
    vis_imvis_i = im_tab[0];
    vis_last_i  = 1'b1;
    for (int c = 0; c < 100 && got_q.size() < 6; c++) begin
      @(posedge bus_clock);
      #1;
    end
    check("rst_six_bytes", 32'(got_q.size()), 32'd6);
    #2;
    bus_reset = 1'b1;
    vis_valid_i = 1'b0;
    vis_last_i  = 1'b0;
    #1;
    check("rst_async",
          32'({vis_ready_o, byte_valid_o, byte_last_o, byte_data_o, frame_seq_o}), 32'h0);
    @(negedge bus_clock);
    @(negedge bus_clock);
    bus_reset = 1'b0;
    run_frame(1, 11);
    exp_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    compare_frame("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
